// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared constants and types for the SRAM port-0 arbiter
// Purpose: default geometry of the 32x1024 byte-masked macro, requester ids,
//          read latency and the read tag carried down the response pipeline.
package sram_arb_pkg;

  localparam int ADDR_WIDTH   = 10;
  localparam int DATA_WIDTH   = 32;
  localparam int NUM_WMASKS   = DATA_WIDTH / 8;

  localparam logic REQ_HOST   = 1'b0;
  localparam logic REQ_ACC    = 1'b1;

  // Edges from grant to the edge that captures macro dout.
  localparam int READ_LATENCY = 2;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter
// Purpose: grants one of two requesters per cycle; on contention the grant
//          goes to prio, which then points at the requester not granted.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req[1:0]    request vector (bit N = requester N)
//   gnt[1:0]    onehot0 grant, combinational, forced to 0 while in reset
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio;

  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (prio == REQ_ACC) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // After a grant, priority passes to the requester that was not served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= REQ_HOST;
    end else if (|gnt) begin
      prio <= gnt[0];
    end
  end

endmodule

// File: rtl/sram_port0_arbiter.sv
// rtl/sram_port0_arbiter.sv - round-robin arbiter and sequencer for SRAM RW port 0
// Purpose: accepts one read or write per cycle from the host bridge (r0) or the
//          accelerator (r1), registers the macro's active-low controls, and
//          returns read data to the issuer two edges after acceptance.
// Ports:
//   clk, rst_n                 clock (also the macro clk0), async active-low reset
//   rN_req_valid/ready         request handshake, transfer on valid && ready
//   rN_req_we/wmask/addr/wdata request fields (wmask only used for writes)
//   rN_rsp_valid/rdata         one-cycle read response pulse and held read data
//   sram_csb0/web0/wmask0/addr0/din0  registered macro port-0 controls
//   sram_dout0                 macro read data, sampled only at the response edge
module sram_port0_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = sram_arb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = sram_arb_pkg::DATA_WIDTH,
  parameter int NUM_WMASKS = sram_arb_pkg::NUM_WMASKS
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  r0_req_valid,
  output logic                  r0_req_ready,
  input  logic                  r0_req_we,
  input  logic [NUM_WMASKS-1:0] r0_req_wmask,
  input  logic [ADDR_WIDTH-1:0] r0_req_addr,
  input  logic [DATA_WIDTH-1:0] r0_req_wdata,
  output logic                  r0_rsp_valid,
  output logic [DATA_WIDTH-1:0] r0_rsp_rdata,

  input  logic                  r1_req_valid,
  output logic                  r1_req_ready,
  input  logic                  r1_req_we,
  input  logic [NUM_WMASKS-1:0] r1_req_wmask,
  input  logic [ADDR_WIDTH-1:0] r1_req_addr,
  input  logic [DATA_WIDTH-1:0] r1_req_wdata,
  output logic                  r1_rsp_valid,
  output logic [DATA_WIDTH-1:0] r1_rsp_rdata,

  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  logic [1:0]            gnt;
  logic                  any_gnt;
  logic                  sel_id;
  logic                  sel_we;
  logic [NUM_WMASKS-1:0] sel_wmask;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  rd_tag_t               issue_tag;
  rd_tag_t               rsp_tag;
  rd_tag_t               tag_q [READ_LATENCY];

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({r1_req_valid, r0_req_valid}),
    .gnt   (gnt)
  );

  assign r0_req_ready = gnt[0];
  assign r1_req_ready = gnt[1];
  assign any_gnt      = |gnt;

  assign sel_id    = gnt[1] ? REQ_ACC : REQ_HOST;
  assign sel_we    = sel_id ? r1_req_we    : r0_req_we;
  assign sel_wmask = sel_id ? r1_req_wmask : r0_req_wmask;
  assign sel_addr  = sel_id ? r1_req_addr  : r0_req_addr;
  assign sel_wdata = sel_id ? r1_req_wdata : r0_req_wdata;

  assign issue_tag = {any_gnt & ~sel_we, sel_id};
  assign rsp_tag   = tag_q[READ_LATENCY-1];

  // Idle cycles deselect the macro and clear the mask; address and data hold
  // so the pins do not toggle needlessly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
    end else if (any_gnt) begin
      sram_csb0   <= 1'b0;
      sram_web0   <= ~sel_we;
      sram_wmask0 <= sel_we ? sel_wmask : '0;
      sram_addr0  <= sel_addr;
      sram_din0   <= sel_wdata;
    end else begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
    end
  end

  // Tag shadow of each issued read; stage 0 loads at the grant edge, the
  // last stage lines up with the edge where macro dout is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= issue_tag;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      r0_rsp_rdata <= '0;
      r1_rsp_rdata <= '0;
    end else begin
      r0_rsp_valid <= rsp_tag.valid && (rsp_tag.id == REQ_HOST);
      r1_rsp_valid <= rsp_tag.valid && (rsp_tag.id == REQ_ACC);
      if (rsp_tag.valid && (rsp_tag.id == REQ_HOST)) begin
        r0_rsp_rdata <= sram_dout0;
      end
      if (rsp_tag.valid && (rsp_tag.id == REQ_ACC)) begin
        r1_rsp_rdata <= sram_dout0;
      end
    end
  end

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// tb/tb_sram_port0_arbiter.sv - self-checking bench for sram_port0_arbiter
module tb_sram_port0_arbiter;

  logic        clk;
  logic        rst_n;
  logic        r0_req_valid, r0_req_ready, r0_req_we, r0_rsp_valid;
  logic [3:0]  r0_req_wmask;
  logic [9:0]  r0_req_addr;
  logic [31:0] r0_req_wdata, r0_rsp_rdata;
  logic        r1_req_valid, r1_req_ready, r1_req_we, r1_rsp_valid;
  logic [3:0]  r1_req_wmask;
  logic [9:0]  r1_req_addr;
  logic [31:0] r1_req_wdata, r1_rsp_rdata;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [9:0]  sram_addr0;
  logic [31:0] sram_din0, sram_dout0;

  int checks = 0;
  int errors = 0;

  sram_port0_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .r0_req_valid (r0_req_valid),
    .r0_req_ready (r0_req_ready),
    .r0_req_we    (r0_req_we),
    .r0_req_wmask (r0_req_wmask),
    .r0_req_addr  (r0_req_addr),
    .r0_req_wdata (r0_req_wdata),
    .r0_rsp_valid (r0_rsp_valid),
    .r0_rsp_rdata (r0_rsp_rdata),
    .r1_req_valid (r1_req_valid),
    .r1_req_ready (r1_req_ready),
    .r1_req_we    (r1_req_we),
    .r1_req_wmask (r1_req_wmask),
    .r1_req_addr  (r1_req_addr),
    .r1_req_wdata (r1_req_wdata),
    .r1_rsp_valid (r1_rsp_valid),
    .r1_rsp_rdata (r1_rsp_rdata),
    .sram_csb0    (sram_csb0),
    .sram_web0    (sram_web0),
    .sram_wmask0  (sram_wmask0),
    .sram_addr0   (sram_addr0),
    .sram_din0    (sram_din0),
    .sram_dout0   (sram_dout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Macro model: latches pins on posedge, commits writes on the following
  // negedge, presents read data shortly after the latch edge.
  logic [31:0] mac_mem [1024];
  logic        lc = 1'b1;
  logic        lw = 1'b1;
  logic [3:0]  lm = 4'h0;
  logic [9:0]  la = 10'h0;
  logic [31:0] ld = 32'h0;

  initial begin
    for (int i = 0; i < 1024; i++) mac_mem[i] = init_word(i);
    sram_dout0 = 32'h0;
    forever begin
      @(posedge clk);
      lc = sram_csb0;
      lw = sram_web0;
      lm = sram_wmask0;
      la = sram_addr0;
      ld = sram_din0;
      #1;
      sram_dout0 = (!lc && lw) ? mac_mem[la] : 32'h5A5A_0BAD;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!lc && !lw) begin
        for (int b = 0; b < 4; b++) begin
          if (lm[b]) mac_mem[la][8*b +: 8] = ld[8*b +: 8];
        end
      end
    end
  end

  // Reference model: expected memory contents, arbitration priority,
  // expected pin values and an in-order queue of pending read responses.
  typedef struct {
    int          due;
    logic        id;
    logic [31:0] data;
  } rsp_t;

  rsp_t        pq[$];
  logic [31:0] m_mem [1024];
  logic        m_prio;
  int          mcyc;
  logic        e_csb, e_web;
  logic [3:0]  e_wm;
  logic [9:0]  e_addr;
  logic [31:0] e_din;
  logic [31:0] e_rd0, e_rd1;

  task automatic model_step();
    logic g0, g1, ev0, ev1, id, we;
    logic [3:0]  wm;
    logic [9:0]  a;
    logic [31:0] d;
    if (!rst_n) begin
      e_csb = 1'b1; e_web = 1'b1; e_wm = 4'h0; e_addr = 10'h0; e_din = 32'h0;
      e_rd0 = 32'h0; e_rd1 = 32'h0;
      pq.delete();
      m_prio = 1'b0;
    end
    g0 = 1'b0; g1 = 1'b0;
    if (rst_n) begin
      if (r0_req_valid && r1_req_valid) begin
        g0 = !m_prio; g1 = m_prio;
      end else begin
        g0 = r0_req_valid; g1 = r1_req_valid;
      end
    end
    ev0 = 1'b0; ev1 = 1'b0;
    if (pq.size() > 0 && pq[0].due == mcyc) begin
      rsp_t r;
      r = pq.pop_front();
      if (r.id) begin ev1 = 1'b1; e_rd1 = r.data; end
      else begin ev0 = 1'b1; e_rd0 = r.data; end
    end
    chk("r0_ready", 32'(r0_req_ready), 32'(g0));
    chk("r1_ready", 32'(r1_req_ready), 32'(g1));
    chk("csb0", 32'(sram_csb0), 32'(e_csb));
    chk("web0", 32'(sram_web0), 32'(e_web));
    chk("wmask0", 32'(sram_wmask0), 32'(e_wm));
    chk("addr0", 32'(sram_addr0), 32'(e_addr));
    chk("din0", sram_din0, e_din);
    chk("r0_rsp_valid", 32'(r0_rsp_valid), 32'(ev0));
    chk("r1_rsp_valid", 32'(r1_rsp_valid), 32'(ev1));
    chk("r0_rsp_rdata", r0_rsp_rdata, e_rd0);
    chk("r1_rsp_rdata", r1_rsp_rdata, e_rd1);
    if (g0 || g1) begin
      id = g1;
      we = id ? r1_req_we    : r0_req_we;
      wm = id ? r1_req_wmask : r0_req_wmask;
      a  = id ? r1_req_addr  : r0_req_addr;
      d  = id ? r1_req_wdata : r0_req_wdata;
      e_csb = 1'b0; e_web = !we; e_addr = a; e_din = d;
      e_wm = we ? wm : 4'h0;
      if (we) begin
        for (int b = 0; b < 4; b++) if (wm[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
      end else begin
        pq.push_back('{mcyc + 3, id, m_mem[a]});
      end
      m_prio = !id;
    end else if (rst_n) begin
      e_csb = 1'b1; e_web = 1'b1; e_wm = 4'h0;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) m_mem[i] = init_word(i);
    m_prio = 1'b0; mcyc = 0;
    e_csb = 1'b1; e_web = 1'b1; e_wm = 4'h0; e_addr = 10'h0; e_din = 32'h0;
    e_rd0 = 32'h0; e_rd1 = 32'h0;
    forever begin
      @(negedge clk);
      mcyc++;
      model_step();
    end
  end

  // Directed stimulus with literal expectations.
  task automatic drive(input logic v0, input logic w0, input logic [3:0] m0,
                       input logic [9:0] a0, input logic [31:0] d0,
                       input logic v1, input logic w1, input logic [3:0] m1,
                       input logic [9:0] a1, input logic [31:0] d1);
    r0_req_valid = v0; r0_req_we = w0; r0_req_wmask = m0; r0_req_addr = a0; r0_req_wdata = d0;
    r1_req_valid = v1; r1_req_we = w1; r1_req_wmask = m1; r1_req_addr = a1; r1_req_wdata = d1;
  endtask

  task automatic idle();
    drive(0, 0, 4'h0, 10'h0, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered one cycle after the accepting edge; response must appear in the
  // third cycle after acceptance and not before.
  task automatic wait_rsp(input logic id, input logic [31:0] data);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c < 3) begin
        chk("rsp_not_early", 32'(id ? r1_rsp_valid : r0_rsp_valid), 32'd0);
      end else begin
        chk("rsp_on_time", 32'(id ? r1_rsp_valid : r0_rsp_valid), 32'd1);
        chk("rsp_data", id ? r1_rsp_rdata : r0_rsp_rdata, data);
      end
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    drive(1, 0, 4'h0, 10'h010, 32'h0, 1, 0, 4'h0, 10'h020, 32'h0);
    #1 rst_n = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_csb0", 32'(sram_csb0), 32'd1);
    chk("rst_web0", 32'(sram_web0), 32'd1);
    chk("rst_r0_ready", 32'(r0_req_ready), 32'd0);
    chk("rst_r1_ready", 32'(r1_req_ready), 32'd0);
    chk("rst_r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
    step();
    rst_n = 1'b1;

    // Contention: both valid for 8 cycles, grants must alternate from r0.
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 4'h0, 10'(16 + i), 32'h0, 1, 0, 4'h0, 10'(32 + i), 32'h0);
      @(negedge clk);
      chk("cont_r0_ready", 32'(r0_req_ready), 32'(i % 2 == 0));
      chk("cont_r1_ready", 32'(r1_req_ready), 32'(i % 2 == 1));
      step();
    end
    idle();
    repeat (4) step();

    // Full write then read back.
    drive(1, 1, 4'hF, 10'h155, 32'hDEADBEEF, 0, 0, 4'h0, 10'h0, 32'h0);
    step();
    drive(1, 0, 4'h0, 10'h155, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0);
    step();
    idle();
    wait_rsp(1'b0, 32'hDEADBEEF);

    // Zero-mask write is issued but changes nothing.
    drive(1, 1, 4'h0, 10'h155, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0);
    step();
    drive(1, 0, 4'h0, 10'h155, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0);
    step();
    idle();
    wait_rsp(1'b0, 32'hDEADBEEF);

    // Byte-lane merge at the top address.
    drive(1, 1, 4'hF, 10'h3FF, 32'h11223344, 0, 0, 4'h0, 10'h0, 32'h0);
    step();
    drive(1, 1, 4'b0101, 10'h3FF, 32'hAABBCCDD, 0, 0, 4'h0, 10'h0, 32'h0);
    step();
    drive(1, 0, 4'h0, 10'h3FF, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0);
    step();
    idle();
    wait_rsp(1'b0, 32'h11BB33DD);

    // r1 write followed immediately by r0 read of the same word.
    drive(0, 0, 4'h0, 10'h0, 32'h0, 1, 1, 4'hF, 10'h000, 32'hCAFEF00D);
    step();
    drive(1, 0, 4'h0, 10'h000, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0);
    step();
    idle();
    wait_rsp(1'b0, 32'hCAFEF00D);

    // Reset the cycle after a read is accepted: its response must vanish.
    drive(1, 0, 4'h0, 10'h155, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0);
    step();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_csb0", 32'(sram_csb0), 32'd1);
    chk("mid_rst_web0", 32'(sram_web0), 32'd1);
    chk("mid_rst_wmask0", 32'(sram_wmask0), 32'd0);
    chk("mid_rst_addr0", 32'(sram_addr0), 32'd0);
    chk("mid_rst_din0", sram_din0, 32'd0);
    chk("mid_rst_r0_rdata", r0_rsp_rdata, 32'd0);
    chk("mid_rst_r0_valid", 32'(r0_rsp_valid), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("dropped_rsp", 32'(r0_rsp_valid), 32'd0);
      step();
    end

    // First grant after release, from r1 alone.
    drive(0, 0, 4'h0, 10'h0, 32'h0, 1, 0, 4'h0, 10'h020, 32'h0);
    @(negedge clk);
    chk("post_rst_r1_ready", 32'(r1_req_ready), 32'd1);
    step();
    idle();
    wait_rsp(1'b1, 32'hA5A50020);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port0_arbiter.md
# sram_port0_arbiter

Two-requester round-robin arbiter and sequencer for the RW port (port 0) of the 32x1024 byte-masked SRAM macro. It accepts one read or write per cycle from either requester, drives the macro's registered active-low controls, and routes read data back to the issuing requester with a fixed latency. It sits between the host-side bus bridge (requester 0) and the accelerator datapath (requester 1). The macro's read-only port 1 is not touched.

## Interface
Parameters:
- ADDR_WIDTH, 10, word address width
- DATA_WIDTH, 32, data width
- NUM_WMASKS, 4, byte-lane write-enable count (DATA_WIDTH/8)

Ports:
- clk  in  1  single clock; also drives the macro's clk0 (same edge, not inverted)
- rst_n  in  1  reset, asynchronous assert, active-low
- rN_req_valid  in  1  request present (N = 0, 1)
- rN_req_ready  out  1  request accepted this cycle
- rN_req_we  in  1  1 = write, 0 = read
- rN_req_wmask  in  NUM_WMASKS  byte enables, used only for writes
- rN_req_addr  in  ADDR_WIDTH  word address
- rN_req_wdata  in  DATA_WIDTH  write data
- rN_rsp_valid  out  1  one-cycle pulse, read data valid
- rN_rsp_rdata  out  DATA_WIDTH  read data
- sram_csb0  out  1  macro chip select, active-low
- sram_web0  out  1  macro write enable, active-low
- sram_wmask0  out  NUM_WMASKS  macro byte mask
- sram_addr0  out  ADDR_WIDTH  macro address
- sram_din0  out  DATA_WIDTH  macro write data
- sram_dout0  in  DATA_WIDTH  macro read data

## Operation
- Arbitration:
  - Combinational, every cycle.
  - Only one requester valid: it is granted.
  - Both valid: grant goes to `prio`. `prio` is a 1-bit register, reset to 0, that flips to the other requester after every grant.
  - rN_req_ready = grant to N. The transfer happens on valid && ready.
  - Ready never asserts without valid.
  - The controller does not stall: at most one grant per cycle, always issued.
- Issue stage (registered at the grant edge):
  - sram_csb0 = 0.
  - sram_web0 = ~we.
  - sram_addr0 = addr.
  - sram_din0 = wdata.
  - sram_wmask0 = we ? wmask : 0.
- No grant in a cycle: sram_csb0 = 1 and sram_web0 = 1 are registered. Address and data are held. wmask0 is set to 0.
- Writes are posted and produce no response.
- A write with wmask = 0 is still issued, with csb0 = 0, and modifies nothing.
- Reads:
  - A 2-deep tag pipeline (valid bit + requester id) shadows each issued read.
  - At stage 2 the controller registers sram_dout0 into rN_rsp_rdata for the tagged requester and pulses rN_rsp_valid.
  - The other requester's rsp_rdata holds its previous value.
- Ordering: responses return in issue order. A read issued the cycle after a write to the same address returns the new data, because the macro commits writes on the negedge of the latch cycle. No hazard logic is required.

## Timing
- Read latency:
  - Grant at edge A.
  - Pins valid after A; macro latches at A+1.
  - Controller registers dout0 at A+2.
  - rsp_valid is high during cycle A+2 to A+3. This is 2 cycles from acceptance.
- Throughput: one access per cycle, reads and writes interleaved freely.
- dout0 goes X T_HOLD after each macro edge. It is sampled only at the stage-2 edge, never combinationally forwarded.
- Reset values:
  - sram_csb0 = 1, sram_web0 = 1.
  - sram_wmask0 = 0, sram_addr0 = 0, sram_din0 = 0.
  - rN_rsp_valid = 0, rN_rsp_rdata = 0.
  - prio = 0, tag pipeline cleared.
  - rN_req_ready = 0 while rst_n = 0.
- Reset mid-operation:
  - In-flight read tags are dropped. No rsp_valid follows reset release.
  - A write latched by the macro before reset may still commit.
- Deassertion: rst_n is synchronized externally. The first grant can occur in the first cycle after release.

## Structure
- Package `sram_arb_pkg` contains:
  - localparams ADDR_WIDTH, DATA_WIDTH, NUM_WMASKS.
  - Requester-id constants REQ_HOST = 0 and REQ_ACC = 1.
  - READ_LATENCY = 2.
- Sub-module `rr_arb2`: a 2-way round-robin arbiter holding `prio` (clk, rst_n, req[1:0] in → gnt[1:0] out, onehot0).
- The top level holds the issue registers, the tag pipeline and the response demux.

## Test plan
- Reset check: hold rst_n = 0 with both valids high → csb0 = 1, web0 = 1, no ready, no rsp_valid. Release → r0 granted first.
- Single write then read:
  - r0 writes 0xDEADBEEF to 0x155 with wmask 4'b1111, then r0 reads 0x155.
  - Expect r0_rsp_valid exactly 2 cycles after the read acceptance, with rdata 0xDEADBEEF.
- Byte mask:
  - Write 0x11223344 to 0x3FF with mask 4'b1111.
  - Then write 0xAABBCCDD with mask 4'b0101.
  - Then read 0x3FF → 0x11BB33DD.
- Contention: both valid every cycle for 8 cycles → grants alternate r0, r1, r0, …. Each read response goes only to its issuer, in order.
- Back-to-back same address: r1 writes 0x0 ← 0xCAFEF00D, and r0 reads 0x0 the next cycle → r0 receives 0xCAFEF00D.
- Reset mid-flight: assert rst_n the cycle after a read is accepted → no rsp_valid ever appears for that read. All outputs are at reset values.
